// File: rtl/rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_stream_reader                                            |
// | Description : Burst reader for a 1-cycle-latency synchronous ROM, emitting |
// |               words as a valid/ready stream with a last marker.            |
// |               Define ROM_READER_CHECKSUM_EN to build the running checksum. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rom_stream_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0]   c_len_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        c_occ_one  = 2'd1;
  localparam logic [1:0]        c_credits  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remain;
  logic                r_inflight;
  logic                r_inflight_last;
  logic [DATA_W-1:0]   r_buf_data [2];
  logic [1:0]          r_buf_last;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;
  logic                r_done;

  logic                w_hs;
  logic                w_accept;
  logic                w_zero_len;
  logic                w_head_last;
  logic [1:0]          w_used;

  assign w_hs        = m_valid && m_ready;
  assign w_accept    = start && (r_state == S_IDLE);
  assign w_zero_len  = (len == '0);
  assign w_head_last = r_buf_last[r_rd_ptr];
  // Credits consumed: words already buffered plus the read whose data lands next edge.
  assign w_used      = r_occ + {1'b0, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    rom_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_zero_len) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        rom_en = (w_used < c_credits) || ((w_used == c_credits) && w_hs);
        if (rom_en && (r_remain == c_len_one)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_hs && w_head_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= rom_en;
      r_inflight_last <= rom_en && (r_remain == c_len_one);
      r_done          <= (w_accept && w_zero_len) ||
                         ((r_state == S_FLUSH) && w_hs && w_head_last);
      if (w_accept && !w_zero_len) begin
        r_addr   <= start_addr;
        r_remain <= len;
      end else if (rom_en) begin
        r_addr   <= r_addr + c_addr_one;
        if (r_remain != '0) r_remain <= r_remain - c_len_one;
      end
    end
  end

  // Two-entry FIFO fed by the ROM read pipeline; the credit rule keeps it from overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= '0;
    end else begin
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= rom_data;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_hs) r_rd_ptr <= ~r_rd_ptr;
      case ({r_inflight, w_hs})
        2'b10:   r_occ <= r_occ + c_occ_one;
        2'b01:   r_occ <= r_occ - c_occ_one;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign rom_addr = r_addr;
  assign m_valid  = (r_occ != '0);
  assign m_data   = r_buf_data[r_rd_ptr];
  assign m_last   = m_valid && w_head_last;

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + m_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rom_stream_reader                                         |
// | Description : Randomized self-checking bench with a burst-level model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [3:0] len = '0;
  logic       busy, done, rom_en, m_valid, m_last;
  logic       m_ready = 1'b1;
  logic [2:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] m_data, checksum;

  int n_total = 0;
  int n_bad   = 0;

  rom_stream_reader #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Burst-level model: expected word k of a burst is mem[(addr+k) mod 8].
  bit   m_busy = 0;
  bit   m_exp_done = 0;
  int   m_addr, m_len, m_issued, m_hs, m_cnt, last_cnt;
  bit   seen_valid, hold_pend, hold_last;
  int   hold_data;
  int   m_sum = 0;

  function automatic int exp_csum();
`ifdef ROM_READER_CHECKSUM_EN
    return m_sum % 256;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    bit hs, was_busy;
    int outst;
    if (!rst_n) begin
      m_busy = 0; m_exp_done = 0; hold_pend = 0; m_sum = 0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", m_valid, 0);
    end else begin
      m_cnt++;
      hs = m_valid && m_ready;
      was_busy = m_busy;
      check("done", done, m_exp_done);
      m_exp_done = 0;
      check("busy", busy, m_busy);
      check("checksum", checksum, exp_csum());
      if (hold_pend) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      if (!m_busy) begin
        check("idle_rom_en", rom_en, 0);
        check("idle_valid", m_valid, 0);
      end else begin
        if (m_valid && !seen_valid) begin
          seen_valid = 1;
          check("first_latency", m_cnt, 3);  // edges E0, E1, E2 seen
        end
        if (rom_en) begin
          outst = m_issued - m_hs;
          check("rom_addr", rom_addr, (m_addr + m_issued) % 8);
          check("credit", int'((outst < 2) || (outst == 2 && hs)), 1);
          check("over_issue", int'(m_issued < m_len), 1);
          m_issued++;
        end
        if (hs) begin
          check("word", m_data, mem[(m_addr + m_hs) % 8]);
          check("last", m_last, int'(m_hs == m_len - 1));
          m_sum += m_data;
          m_hs++;
          if (m_hs == m_len) begin
            m_busy = 0; m_exp_done = 1; last_cnt = m_cnt;
          end
        end
      end
      if (start && !was_busy) begin
        m_sum = 0;
        if (len == 0) m_exp_done = 1;
        else begin
          m_busy = 1; m_addr = start_addr; m_len = len;
          m_issued = 0; m_hs = 0; m_cnt = 0; seen_valid = 0;
        end
      end
    end
  end

  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic issue_start(input int a, input int l);
    start = 1'b1; start_addr = 3'(a); len = 4'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit settle);
    int k = 0;
    while (m_busy && k < 300) begin step(); k++; end
    if (k >= 300) check("timeout", 0, 1);
    if (settle) begin step(); step(); end
  endtask

  initial begin
    int k;
    repeat (2) step();
    check("reset_rom_en", rom_en, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    rst_n = 1'b1;
    step();

    // Full 8-word burst at full throughput
    rdy_mode = 0;
    issue_start(0, 8);
    wait_idle(1'b0);
    check("throughput", last_cnt, 10);
    step();
`ifdef ROM_READER_CHECKSUM_EN
    check("sum8", checksum, 36);
`else
    check("sum8", checksum, 0);
`endif
    step();

    // Address wrap
    issue_start(6, 4);
    wait_idle(1'b1);

    // Backpressure: ready low for 6 cycles once the first word is shown
    rdy_mode = 2;
    m_ready = 1'b0;
    issue_start(0, 5);
    k = 0;
    while (!m_valid && k < 10) begin step(); k++; end
    if (k >= 10) check("bp_timeout", 0, 1);
    repeat (6) begin
      step();
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 1);
    end
    check("bp_issues", m_issued, 2);
    rdy_mode = 0;
    wait_idle(1'b1);

    // Zero-length command
    issue_start(3, 0);
    step(); step();

    // Start while busy is ignored
    issue_start(2, 6);
    step(); step();
    issue_start(5, 1);
    wait_idle(1'b1);

    // Reset during word 3 of an 8-word burst
    rdy_mode = 0;
    issue_start(0, 8);
    k = 0;
    while (m_hs < 2 && k < 20) begin step(); k++; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rom_en", rom_en, 0);
    check("arst_rom_addr", rom_addr, 0);
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_last", m_last, 0);
    check("arst_checksum", checksum, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    issue_start(0, 2);
    wait_idle(1'b1);

    // Randomized back-to-back bursts, including starts in the done cycle
    rdy_mode = 1;
    for (int b = 0; b < 25; b++) begin
      issue_start($urandom_range(0, 7), $urandom_range(0, 8));
      wait_idle($urandom_range(0, 1) == 1);
    end
    rdy_mode = 0;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
